pipelined_add_sub: RTL and testbench

Parametrised, segmented pipelined adder/subtractor for the multiplier datapath, generalising the fixed 5-bit ripple-carry adder.
- Splits a WIDTH-bit add or subtract into SEG-bit ripple segments, one segment per pipeline stage, with the inter-segment carry registered between stages.
- Accepts one operation per cycle under a valid/ready handshake with full backpressure.
- Returns sum, carry-out and signed overflow.
- Serves as the final carry-propagate adder after the Wallace reduction tree.

---
 rtl/pipelined_add_sub.sv | 132 +++++++++++++
 tb/tb_pipelined_add_sub.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_add_sub.sv
// ============================================================================
// Module   : pipelined_add_sub
// Brief    : Segmented pipelined adder/subtractor, one SEG-bit ripple per stage
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_add_sub #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SEG;

  logic w_stall;
  logic w_adv;

  assign w_stall  = out_valid && !out_ready;
  assign w_adv    = !w_stall;
  assign in_ready = w_adv;

  // Operand capture: B is inverted here so the ripple stages only ever add.
  logic             r_in_v;
  logic             r_in_c;
  logic [WIDTH-1:0] r_in_a;
  logic [WIDTH-1:0] r_in_b;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_in_v <= 1'b0;
      r_in_c <= 1'b0;
      r_in_a <= '0;
      r_in_b <= '0;
    end else if (w_adv) begin
      r_in_v <= in_valid;
      r_in_c <= sub;
      r_in_a <= A;
      r_in_b <= B ^ {WIDTH{sub}};
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = k * SEG;
    localparam int REM = WIDTH - LO;

    logic              w_v;
    logic              w_c;
    logic [REM-1:0]    w_a;
    logic [REM-1:0]    w_b;
    logic [SEG:0]      w_sum;
    logic [LO+SEG-1:0] w_s;

    logic              r_v;
    logic              r_c;
    logic [LO+SEG-1:0] r_s;

    if (k == 0) begin : g_head
      assign w_v = r_in_v;
      assign w_c = r_in_c;
      assign w_a = r_in_a;
      assign w_b = r_in_b;
      assign w_s = w_sum[SEG-1:0];
    end else begin : g_body
      assign w_v = g_stage[k-1].r_v;
      assign w_c = g_stage[k-1].r_c;
      assign w_a = g_stage[k-1].g_fwd.r_a;
      assign w_b = g_stage[k-1].g_fwd.r_b;
      assign w_s = {w_sum[SEG-1:0], g_stage[k-1].r_s};
    end

    assign w_sum = {1'b0, w_a[SEG-1:0]} + {1'b0, w_b[SEG-1:0]} + {{SEG{1'b0}}, w_c};

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_s <= '0;
      end else if (w_adv) begin
        r_v <= w_v;
        r_c <= w_sum[SEG];
        r_s <= w_s;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [REM-SEG-1:0] r_a;
      logic [REM-SEG-1:0] r_b;

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv) begin
          r_a <= w_a[REM-1:SEG];
          r_b <= w_b[REM-1:SEG];
        end
      end
    end else begin : g_last
      logic r_ovf;

      // Carry into the MSB is recovered as a^b^s at that bit.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          r_ovf <= 1'b0;
        end else if (w_adv) begin
          r_ovf <= w_a[REM-1] ^ w_b[REM-1] ^ w_sum[SEG-1] ^ w_sum[SEG];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].r_v;
  assign S         = g_stage[STAGES-1].r_s;
  assign cout      = g_stage[STAGES-1].r_c;
  assign ovf       = g_stage[STAGES-1].g_last.r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_add_sub.sv
// ============================================================================
// Module   : tb_pipelined_add_sub
// Brief    : Scoreboard bench for pipelined_add_sub at three parameter points
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipelined_add_sub;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a16, b16, s16;
  logic        sub16, cout16, ovf16;

  logic        v5, rdy5, vo5, sub5, co5, of5;
  logic [4:0]  a5, b5, s5;
  logic        v32, rdy32, vo32, sub32, co32, of32;
  logic [31:0] a32, b32, s32;

  always #5 clk = ~clk;

  pipelined_add_sub #(.WIDTH(16), .SEG(4)) u_dut (
    .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(a16), .B(b16), .sub(sub16), .out_valid(out_valid), .out_ready(out_ready),
    .S(s16), .cout(cout16), .ovf(ovf16)
  );

  pipelined_add_sub #(.WIDTH(5), .SEG(5)) u_w5 (
    .CLK(clk), .RST(rst), .in_valid(v5), .in_ready(rdy5),
    .A(a5), .B(b5), .sub(sub5), .out_valid(vo5), .out_ready(1'b1),
    .S(s5), .cout(co5), .ovf(of5)
  );

  pipelined_add_sub #(.WIDTH(32), .SEG(8)) u_w32 (
    .CLK(clk), .RST(rst), .in_valid(v32), .in_ready(rdy32),
    .A(a32), .B(b32), .sub(sub32), .out_valid(vo32), .out_ready(1'b1),
    .S(s32), .cout(co32), .ovf(of32)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  typedef struct {
    logic [63:0] s;
    logic        co;
    logic        ov;
    int          c0;
    int          st0;
  } exp_t;

  exp_t sb[$];
  exp_t q5[$];
  exp_t q32[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int stall_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_s;
  logic        prev_co, prev_ov;
  logic        bp_done;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail_msg(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Independent reference: sign-rule overflow on a w-bit add/subtract.
  function automatic logic [65:0] ref_op(input int w, input logic [63:0] a,
                                         input logic [63:0] b, input logic s);
    logic [64:0] full;
    logic [63:0] mask, bb, r;
    logic        co, ov;
    mask = (64'd1 << w) - 64'd1;
    bb   = (s ? ~b : b) & mask;
    full = {1'b0, a & mask} + {1'b0, bb} + {64'd0, s};
    r    = full[63:0] & mask;
    co   = full[w];
    ov   = (a[w-1] == bb[w-1]) && (r[w-1] != a[w-1]);
    return {co, ov, r};
  endfunction

  // Called at posedge+#1; returns at posedge+#1 after the op is accepted.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s,
                      input logic [15:0] es, input logic eco, input logic eov);
    bit ok = 1'b0;
    in_valid = 1'b1; a16 = a; b16 = b; sub16 = s;
    for (int w = 0; w < 300; w++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{64'(es), eco, eov, cyc, stall_cnt});
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) fail_msg("send_timeout");
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while ((sb.size() != 0 || q5.size() != 0 || q32.size() != 0) && w < 400) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 400) fail_msg("drain_timeout");
  endtask

  // Main-instance monitor: handshake law, stall stability, ordered scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      chk("in_ready_law", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (prev_stall) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_S", 64'(s16), 64'(prev_s));
        chk("hold_cout", 64'(cout16), 64'(prev_co));
        chk("hold_ovf", 64'(ovf16), 64'(prev_ov));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          fail_msg("unexpected_result");
        end else begin
          e = sb.pop_front();
          chk("S", 64'(s16), e.s);
          chk("cout", 64'(cout16), 64'(e.co));
          chk("ovf", 64'(ovf16), 64'(e.ov));
          chk("latency", 64'(cyc - e.c0 - 1), 64'(4 + stall_cnt - e.st0));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_s = s16; prev_co = cout16; prev_ov = ovf16;
      if (prev_stall) stall_cnt++;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && vo5) begin
      if (q5.size() == 0) fail_msg("w5_unexpected");
      else begin
        e = q5.pop_front();
        chk("w5_S", 64'(s5), e.s);
        chk("w5_cout", 64'(co5), 64'(e.co));
        chk("w5_ovf", 64'(of5), 64'(e.ov));
        chk("w5_latency", 64'(cyc - e.c0 - 1), 64'd1);
      end
    end
    if (!rst && vo32) begin
      if (q32.size() == 0) fail_msg("w32_unexpected");
      else begin
        e = q32.pop_front();
        chk("w32_S", 64'(s32), e.s);
        chk("w32_cout", 64'(co32), 64'(e.co));
        chk("w32_ovf", 64'(of32), 64'(e.ov));
        chk("w32_latency", 64'(cyc - e.c0 - 1), 64'd4);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[9];
    logic [65:0] r;
    logic [15:0] ra, rb;
    logic        rs;
    bit          seen;

    vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vt[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vt[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vt[5] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
    vt[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vt[7] = '{16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b0};
    vt[8] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1};

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a16 = '0; b16 = '0; sub16 = 1'b0;
    v5 = 1'b0; a5 = '0; b5 = '0; sub5 = 1'b0;
    v32 = 1'b0; a32 = '0; b32 = '0; sub32 = 1'b0;
    bp_done = 1'b0;

    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_S", 64'(s16), 64'd0);
    chk("rst_cout", 64'(cout16), 64'd0);
    chk("rst_ovf", 64'(ovf16), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_w5_valid", 64'(vo5), 64'd0);
    chk("rst_w32_valid", 64'(vo32), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed vectors, streamed back to back.
    for (int i = 0; i < 9; i++)
      send(vt[i].a, vt[i].b, vt[i].sub, vt[i].s, vt[i].co, vt[i].ov);
    drain();

    // Backpressure stream of 20 random ops; begins with a 5-cycle low run.
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
          r = ref_op(16, 64'(ra), 64'(rb), rs);
          send(ra, rb, rs, r[15:0], r[65], r[64]);
        end
        bp_done = 1'b1;
      end
      begin
        int run = 5;
        while (!bp_done) begin
          @(posedge clk); #1;
          if (run > 0) begin
            out_ready = 1'b0; run--;
          end else if ($urandom_range(0, 9) == 0) begin
            out_ready = 1'b0; run = 4;
          end else begin
            out_ready = 1'($urandom_range(0, 1));
          end
        end
      end
    join
    @(posedge clk); #1 out_ready = 1'b1;
    drain();

    // Reset with three ops in flight and the first one stalled at the output.
    out_ready = 1'b0;
    send(16'h8001, 16'h8000, 1'b0, 16'h0001, 1'b1, 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    seen = 1'b0;
    for (int w = 0; w < 20 && !seen; w++) begin
      @(negedge clk);
      seen = out_valid;
    end
    if (!seen) fail_msg("mid_reset_no_output");
    #2 rst = 1'b1;
    #1;
    sb.delete();
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_S", 64'(s16), 64'd0);
    chk("midrst_cout", 64'(cout16), 64'd0);
    chk("midrst_ovf", 64'(ovf16), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
    drain();
    repeat (6) @(posedge clk);
    #1 chk("post_reset_no_stale", 64'(sb.size()), 64'd0);

    // Parameter sweep: WIDTH=5 exhaustive, WIDTH=32 random, streamed together.
    for (int i = 0; i < 2048; i++) begin
      v5 = 1'b1; a5 = 5'(i); b5 = 5'(i >> 5); sub5 = 1'(i >> 10);
      v32 = 1'b1; a32 = $urandom; b32 = $urandom; sub32 = 1'($urandom);
      if (i % 64 == 0) begin a32 = 32'h7FFF_FFFF; b32 = 32'h8000_0000; sub32 = 1'b1; end
      @(negedge clk);
      r = ref_op(5, 64'(a5), 64'(b5), sub5);
      if (rdy5) q5.push_back('{r[63:0], r[65], r[64], cyc, 0});
      else fail_msg("w5_not_ready");
      r = ref_op(32, 64'(a32), 64'(b32), sub32);
      if (rdy32) q32.push_back('{r[63:0], r[65], r[64], cyc, 0});
      else fail_msg("w32_not_ready");
      @(posedge clk); #1;
    end
    v5 = 1'b0; v32 = 1'b0;
    drain();
    repeat (4) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
